// File: rtl/cdb_broadcast_if.sv
// rtl/cdb_broadcast_if.sv - functional-unit result inputs and common-data-bus outputs
interface cdb_broadcast_if #(
  parameter int BITWIDTH = 32,
  parameter int NRALUOP  = 8,
  parameter int RS_DEPTH = 8
);
  localparam int TAGW = $clog2(NRALUOP) + $clog2(RS_DEPTH);

  logic [NRALUOP-1:0]               FU_valid;
  logic [NRALUOP-1:0][TAGW-1:0]     FU_tag;
  logic [NRALUOP-1:0][BITWIDTH-1:0] FU_value;
  logic [NRALUOP-1:0]               FU_ready;
  logic                             CDB_valid;
  logic [TAGW-1:0]                  CDB_tag;
  logic [BITWIDTH-1:0]              CDB_value;

  modport master (
    output FU_valid, FU_tag, FU_value,
    input  FU_ready, CDB_valid, CDB_tag, CDB_value
  );

  modport slave (
    input  FU_valid, FU_tag, FU_value,
    output FU_ready, CDB_valid, CDB_tag, CDB_value
  );
endinterface

// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - per-unit holding registers with round-robin common-data-bus broadcast
// CDB_PERF_EN adds the Conflict_cnt contention counter output.
module cdb_broadcast #(
  parameter int BITWIDTH = 32,
  parameter int NRALUOP  = 8,
  parameter int RS_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          Flush,
  cdb_broadcast_if.slave bus
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]   Conflict_cnt
`endif
);
  localparam int TAGW = $clog2(NRALUOP) + $clog2(RS_DEPTH);
  localparam int PTRW = $clog2(NRALUOP);

  logic [NRALUOP-1:0]               occ;
  logic [NRALUOP-1:0]               grant;
  logic [NRALUOP-1:0]               hs;
  logic [NRALUOP-1:0][TAGW-1:0]     hold_tag;
  logic [NRALUOP-1:0][BITWIDTH-1:0] hold_val;
  logic [PTRW-1:0]                  ptr;
  logic [PTRW-1:0]                  gidx;
  logic [PTRW-1:0]                  idx;
  logic                             found;
  logic                             live;

  assign live = en & ~Flush;

  // First occupied slot at or after ptr; NRALUOP is a power of two so the index wraps naturally.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NRALUOP; k++) begin
      idx = ptr + PTRW'(k);
      if (!found && occ[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant = '0;
    if (found && live) grant[gidx] = 1'b1;
  end

  // A slot being broadcast this cycle can be refilled on the same edge.
  assign bus.FU_ready = {NRALUOP{live & ~rst}} & (~occ | grant);
  assign hs           = bus.FU_valid & bus.FU_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ           <= '0;
      hold_tag      <= '0;
      hold_val      <= '0;
      ptr           <= '0;
      bus.CDB_valid <= 1'b0;
      bus.CDB_tag   <= '0;
      bus.CDB_value <= '0;
    end else if (Flush) begin
      occ           <= '0;
      bus.CDB_valid <= 1'b0;
    end else if (!en) begin
      bus.CDB_valid <= 1'b0;
    end else begin
      bus.CDB_valid <= found;
      if (found) begin
        bus.CDB_tag   <= hold_tag[gidx];
        bus.CDB_value <= hold_val[gidx];
        ptr           <= gidx + PTRW'(1);
      end
      occ <= (occ & ~grant) | hs;
      for (int i = 0; i < NRALUOP; i++) begin
        if (hs[i]) begin
          hold_tag[i] <= bus.FU_tag[i];
          hold_val[i] <= bus.FU_value[i];
        end
      end
    end
  end

`ifdef CDB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Conflict_cnt <= '0;
    end else if (live && ($countones(occ) >= 2) && (Conflict_cnt != 32'hFFFF_FFFF)) begin
      Conflict_cnt <= Conflict_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/cdb_broadcast.md
# cdb_broadcast

Common-data-bus writeback stage of the out-of-order extension. It collects completed results from the NRALUOP functional units, one per reservation station, and buffers each in a one-entry holding register. A round-robin arbiter then broadcasts exactly one result per cycle as a (tag, value) pair, which the reservation stations and the register alias table snoop to wake operands and retire renames. It is the return path for entries dispatched from the reservation stations.

## Interface
Parameters:
- BITWIDTH, 32, result data width
- NRALUOP, 8, number of functional units / reservation stations (power of two, ≥2)
- RS_DEPTH, 8, slots per reservation station (power of two)
- TAGW (localparam), $clog2(NRALUOP)+$clog2(RS_DEPTH), tag = {RS id, slot index}

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; low freezes the block
- Flush  in  1  squash all pending results (mispredict)
- FU_valid  in  [NRALUOP]  unit i presents a result
- FU_tag  in  [NRALUOP][TAGW]  tag of unit i's result
- FU_value  in  [NRALUOP][BITWIDTH]  value of unit i's result
- FU_ready  out  [NRALUOP]  holding register i can accept this cycle
- CDB_valid  out  1  broadcast valid (single-cycle pulse per result)
- CDB_tag  out  TAGW  broadcast tag
- CDB_value  out  BITWIDTH  broadcast value

## Operation
- Per unit i: occ[i], hold_tag[i], hold_val[i]. A handshake (FU_valid[i] & FU_ready[i] at a rising edge) loads hold_* and sets occ[i].
- FU_ready[i] = en & ~Flush & (~occ[i] | grant[i]). This is combinational from registered state and the en/Flush inputs, with no path from FU_valid. Grant and reload in the same cycle is allowed, giving full throughput per unit.
- Arbiter: combinational round-robin over occ, searching from index ptr upward with wrap. grant is one-hot or zero, and is zero when en=0 or Flush=1.
- On a grant to i: CDB_valid<=1, CDB_tag<=hold_tag[i], CDB_value<=hold_val[i], occ[i] clears unless reloaded the same edge, and ptr<=(i+1) mod NRALUOP.
- No grant: CDB_valid<=0. CDB_tag and CDB_value hold their last values.
- Flush=1 at an edge: all occ clear, CDB_valid<=0, ptr unchanged, no loads. A result presented on the Flush cycle is dropped.
- en=0 at an edge: occ, hold_*, ptr and CDB_tag/value hold, and CDB_valid<=0. No result is lost.
- Tags pass through unmodified. No arithmetic is performed on values.

## Timing
- Reset values: CDB_valid=0, CDB_tag=0, CDB_value=0, occ=0, ptr=0, hold_*=0. FU_ready = en & ~Flush while reset is deasserted. During reset FU_ready=0.
- Latency: handshake at edge k, earliest CDB_valid in the cycle after edge k+1 (2 cycles).
- Throughput: one broadcast per cycle aggregate. With all units streaming, each unit is granted once every NRALUOP cycles.
- Starvation bound: an occupied unit is granted within NRALUOP cycles of enabled, unflushed operation.
- Reset asserted mid-operation clears all state immediately. Pending results are lost. The first handshake is possible at the first edge after deassertion.
- Simultaneous events: for Flush together with a handshake, Flush wins. For en=0 together with Flush=1, Flush wins.

## Configuration
- CDB_PERF_EN defined: adds output Conflict_cnt (32 bits, reset 0). It increments by 1 at each enabled, unflushed edge where popcount(occ)≥2, and saturates at 2^32-1. Flush does not clear it.
- CDB_PERF_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Single result: unit 3 sends tag=0x1A, value=0xDEADBEEF at edge 0. Required: CDB_valid=1, CDB_tag=0x1A, CDB_value=0xDEADBEEF after edge 1 only, and FU_ready[3]=1 throughout.
- Full contention: all 8 units valid every cycle from reset with tag=i. Required: CDB_tag sequence 0,1,…,7,0,… with CDB_valid held 1 continuously. With CDB_PERF_EN, Conflict_cnt=8 after 8 broadcast cycles.
- Back-pressure: unit 5 holds an unbroadcast result while units 0–4 win. Required: FU_ready[5]=0 until the grant cycle of 5, and a new FU_value on 5 is not captured while it is low.
- Flush: units 1 and 2 occupied, Flush for one cycle. Required: CDB_valid=0 for the next two cycles, no tags 1/2 ever broadcast, and ptr unchanged.
- Enable freeze: en=0 for 4 cycles with units 0 and 6 occupied. Required: CDB_valid=0 during the freeze, then tags 0 and 6 broadcast in round-robin order after en returns.
- Async reset: assert rst mid-stream between edges. Required: CDB_valid and FU_ready drop immediately, and the first broadcast after deassertion is a freshly handshaken result.
